fila_prioridade_ctrl: RTL

Sequential front end for the priority-queue service logic. Counts customer arrivals per category: T (top priority), C (second priority) and A (common). Issues sequential per-category ticket numbers. Presents the level signals T and C that the combinational priority stage consumes. On an attendant request it performs the call with a valid/ack handshake toward the call display. Arbitration order is fixed: T > C > A.

---
 rtl/fila_prioridade_ctrl_pkg.sv | 17 +
 rtl/fila_prioridade_ctrl_if.sv | 31 +++
 rtl/fila_prioridade_ctrl_contador_cat.sv | 50 +++++
 rtl/fila_prioridade_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/fila_prioridade_ctrl_pkg.sv
// Shared encodings for the priority-queue front end: call categories and FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package fila_pkg;

    typedef logic [1:0] cat_t;

    localparam cat_t CAT_NONE = 2'b00;
    localparam cat_t CAT_T    = 2'b01;
    localparam cat_t CAT_C    = 2'b10;
    localparam cat_t CAT_A    = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALL = 1'b1
    } state_t;

endpackage

// File: rtl/fila_prioridade_ctrl_if.sv
// Arrival, call-request and call-display signals of the queue front end.
// The display holds off a presented call by withholding ack.
interface fila_prioridade_ctrl_if #(
    parameter int NUM_W = 8
);
    import fila_pkg::*;

    logic             T_in;
    logic             C_in;
    logic             A_in;
    logic             next;
    logic             ack;
    logic             T;
    logic             C;
    logic             A;
    logic             call_valid;
    cat_t             call_cat;
    logic [NUM_W-1:0] call_num;
    logic             drop;

    modport master (
        output T_in, C_in, A_in, next, ack,
        input  T, C, A, call_valid, call_cat, call_num, drop
    );

    modport slave (
        input  T_in, C_in, A_in, next, ack,
        output T, C, A, call_valid, call_cat, call_num, drop
    );

endinterface

// File: rtl/fila_prioridade_ctrl_contador_cat.sv
// Per-category ticket bookkeeping: issue/serve/wait counters, full check, nonempty flag.
// Flag updates one cycle after arrive/serve; arrivals seen while full are refused, never queued.
module fila_contador_cat #(
    parameter int MAX_WAIT = 15,
    parameter int NUM_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive,
    input  logic             serve,
    output logic [NUM_W-1:0] head_num,
    output logic             nonempty,
    output logic             full
);

    logic [NUM_W-1:0] issue_cnt;
    logic [NUM_W-1:0] serve_cnt;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_nxt;
    logic             accept;

    assign full     = (wait_cnt == 8'(MAX_WAIT));
    assign accept   = arrive && !full;
    assign head_num = serve_cnt;

    // Arrival and service in the same cycle cancel out.
    always_comb begin
        wait_nxt = wait_cnt;
        case ({accept, serve})
            2'b10:   wait_nxt = wait_cnt + 8'd1;
            2'b01:   wait_nxt = wait_cnt - 8'd1;
            default: wait_nxt = wait_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            serve_cnt <= '0;
            wait_cnt  <= '0;
            nonempty  <= 1'b0;
        end else begin
            if (accept) issue_cnt <= issue_cnt + 1'b1;
            if (serve)  serve_cnt <= serve_cnt + 1'b1;
            wait_cnt <= wait_nxt;
            nonempty <= (wait_nxt != 8'd0);
        end
    end

endmodule

// File: rtl/fila_prioridade_ctrl.sv
// Priority-queue front end: counts arrivals, arbitrates T > C > A, presents calls to the display.
// next->call_valid 1 cycle; call held until ack, next ignored while a call is outstanding.
module fila_prioridade_ctrl
    import fila_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int NUM_W    = 8
) (
    input logic                 clk,
    input logic                 rst,
    fila_prioridade_ctrl_if.slave bus
);

    logic [2:0]       arrive;
    logic [2:0]       serve;
    logic [2:0]       nonempty;
    logic [2:0]       full;
    logic [NUM_W-1:0] head_t, head_c, head_a;

    state_t           state, state_nxt;
    cat_t             sel_cat;
    logic [NUM_W-1:0] sel_num;
    logic             load;
    cat_t             call_cat_q;
    logic [NUM_W-1:0] call_num_q;
    logic             drop_q;

    assign arrive = {bus.A_in, bus.C_in, bus.T_in};

    fila_contador_cat #(.MAX_WAIT(MAX_WAIT), .NUM_W(NUM_W)) u_cat_t (
        .clk(clk), .rst(rst), .arrive(arrive[0]), .serve(serve[0]),
        .head_num(head_t), .nonempty(nonempty[0]), .full(full[0])
    );

    fila_contador_cat #(.MAX_WAIT(MAX_WAIT), .NUM_W(NUM_W)) u_cat_c (
        .clk(clk), .rst(rst), .arrive(arrive[1]), .serve(serve[1]),
        .head_num(head_c), .nonempty(nonempty[1]), .full(full[1])
    );

    fila_contador_cat #(.MAX_WAIT(MAX_WAIT), .NUM_W(NUM_W)) u_cat_a (
        .clk(clk), .rst(rst), .arrive(arrive[2]), .serve(serve[2]),
        .head_num(head_a), .nonempty(nonempty[2]), .full(full[2])
    );

    // Registered nonempty flags mirror pre-edge wait counts, so same-cycle arrivals are not eligible.
    always_comb begin
        sel_cat = CAT_NONE;
        sel_num = '0;
        if (nonempty[0]) begin
            sel_cat = CAT_T;
            sel_num = head_t;
        end else if (nonempty[1]) begin
            sel_cat = CAT_C;
            sel_num = head_c;
        end else if (nonempty[2]) begin
            sel_cat = CAT_A;
            sel_num = head_a;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        serve     = 3'b000;
        case (state)
            ST_IDLE: begin
                if (bus.next && (sel_cat != CAT_NONE)) begin
                    load      = 1'b1;
                    serve     = {sel_cat == CAT_A, sel_cat == CAT_C, sel_cat == CAT_T};
                    state_nxt = ST_CALL;
                end
            end
            ST_CALL: begin
                if (bus.ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            call_cat_q <= CAT_NONE;
            call_num_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= |(arrive & full);
            if (load) begin
                call_cat_q <= sel_cat;
                call_num_q <= sel_num;
            end
        end
    end

    assign bus.T          = nonempty[0];
    assign bus.C          = nonempty[1];
    assign bus.A          = nonempty[2];
    assign bus.call_valid = (state == ST_CALL);
    assign bus.call_cat   = call_cat_q;
    assign bus.call_num   = call_num_q;
    assign bus.drop       = drop_q;

endmodule
